pattern_scan_engine: RTL
========================

PATTERN_SCAN_ENGINE -- requirements
Module: pattern_scan_engine

Interface
REQ-001 SHALL have parameter NBYTES, default 32, meaning message length in bytes; legal range 2..32.
REQ-002 SHALL have parameter PAT_ADDR, default 32, meaning data-memory address holding the pattern byte.
REQ-003 SHALL have parameter RES_ADDR, default 33, meaning first of three consecutive result addresses.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to run one scan; sampled on rising edge of clk.
REQ-007 ack  output  1  done flag; high while results are valid in memory.
REQ-008 mem_addr  output  8  data-memory address.
REQ-009 mem_wr_en  output  1  data-memory write strobe.
REQ-010 mem_wr_data  output  8  data-memory write data.
REQ-011 mem_rd_data  input  8  data-memory read data, valid one cycle after mem_addr is presented.

Function
REQ-012 SHALL implement states IDLE, RD_PAT, LD_PAT, SCAN, WR_B, WR_O, WR_S, DONE.
REQ-013 IDLE: start=1 -> RD_PAT; otherwise hold.
REQ-014 RD_PAT: mem_addr=PAT_ADDR; next LD_PAT.
REQ-015 LD_PAT: latch pattern P = mem_rd_data[4:0]; mem_addr=0; clear counters ctb, cto, cts and index i; next SCAN.
REQ-016 SCAN, cycle i (0..NBYTES-1): byte B_i = mem_rd_data; mem_addr=i+1 (don't-care on last cycle); after i=NBYTES-1 go to WR_B.
REQ-017 ctb += count of P in B_i[4:0], B_i[5:1], B_i[6:2], B_i[7:3] (0..4 per byte).
REQ-018 cto += 1 when at least one of those four fields equals P.
REQ-019 cts: message is MSB-first bit string, byte 0 first; i=0 adds the 4 in-byte matches; i>=1 adds matches among the 8 windows W[11:7]..W[4:0] of W={B_(i-1)[3:0],B_i}; total windows 8*NBYTES-4.
REQ-020 SHALL keep B_(i-1)[3:0] in a register to form cross-byte windows.
REQ-021 WR_B: mem_wr_en=1, mem_addr=RES_ADDR, data=ctb; WR_O: RES_ADDR+1, cto; WR_S: RES_ADDR+2, cts; then DONE.
REQ-022 mem_wr_en SHALL be 0 in every state other than WR_B, WR_O, WR_S.
REQ-023 DONE: ack=1; hold until start=1, then -> RD_PAT with ack=0 from the next cycle.
REQ-024 ack SHALL be 0 in all states except DONE.
REQ-025 Latency: start sampled in IDLE at cycle 0 -> ack first high at cycle NBYTES+6 (38 for default).
REQ-026 start asserted in any state other than IDLE/DONE SHALL be ignored.
REQ-027 Counters SHALL be 8 bits, unsigned; no saturation needed (max 4*NBYTES, NBYTES, 8*NBYTES-4 all <=252).
REQ-028 Memory outside PAT_ADDR, 0..NBYTES-1, RES_ADDR..RES_ADDR+2 SHALL never be accessed.

Reset
REQ-029 reset=1 SHALL, at the next clk edge, force IDLE, ack=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, clear counters, index, pattern and prev-byte register.
REQ-030 reset SHALL take priority over start in the same cycle.
REQ-031 reset mid-scan SHALL abort with no result writes; next start performs a full fresh scan.

Verification
REQ-032 All bytes 0x00, P=00000 -> mem[33]=128, mem[34]=32, mem[35]=252, ack at cycle 38.
REQ-033 All bytes 0x55, P=10101 -> mem[33]=64, mem[34]=32, mem[35]=126.
REQ-034 Byte0=0xF8, rest 0x00, P=11111 -> 1, 1, 1.
REQ-035 Byte0=0x07, byte1=0xC0, rest 0x00, P=11111 -> 0, 0, 1 (cross-byte only).
REQ-036 Assert reset during SCAN at i=10 -> no writes to 33..35, ack stays 0; rerun with start gives REQ-032 results.
REQ-037 Second start while in DONE with new data -> ack drops next cycle, new results written, ack returns after 38 cycles; start pulsed mid-SCAN has no effect.

Source files
------------

// File: rtl/pattern_scan_engine.sv
// Scans an NBYTES message in data memory for a 5-bit pattern and writes three
// match counts (byte-aligned fields, bytes with any hit, full bit-stream windows).
module pattern_scan_engine #(
  parameter int unsigned NBYTES   = 32,
  parameter int unsigned PAT_ADDR = 32,
  parameter int unsigned RES_ADDR = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       ack,
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  input  logic [7:0] mem_rd_data
);

  typedef enum logic [2:0] {
    IDLE, RD_PAT, LD_PAT, SCAN, WR_B, WR_O, WR_S, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  pat_q, pat_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  ctb_q, ctb_d;
  logic [7:0]  cto_q, cto_d;
  logic [7:0]  cts_q, cts_d;
  logic [3:0]  prev_q, prev_d;

  logic [11:0] win;
  logic [7:0]  win_m;
  logic [3:0]  byte_hits;
  logic [3:0]  win_hits;
  logic        last_byte;

  // Windows 0..3 lie wholly inside the current byte; 4..7 straddle the previous one.
  always_comb begin
    win       = {prev_q, mem_rd_data};
    byte_hits = '0;
    win_hits  = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      win_m[j] = (win[j+4 -: 5] == pat_q);
      win_hits = win_hits + {3'b000, win_m[j]};
      if (j < 4) byte_hits = byte_hits + {3'b000, win_m[j]};
    end
  end

  assign last_byte = (idx_q == 8'(NBYTES - 1));

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    idx_d       = idx_q;
    ctb_d       = ctb_q;
    cto_d       = cto_q;
    cts_d       = cts_q;
    prev_d      = prev_q;
    ack         = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RD_PAT;
      end
      RD_PAT: begin
        mem_addr = 8'(PAT_ADDR);
        state_d  = LD_PAT;
      end
      LD_PAT: begin
        pat_d   = mem_rd_data[4:0];
        ctb_d   = '0;
        cto_d   = '0;
        cts_d   = '0;
        idx_d   = '0;
        prev_d  = '0;
        state_d = SCAN;
      end
      SCAN: begin
        // Next-byte address is parked at 0 on the final byte to stay in range.
        mem_addr = last_byte ? 8'd0 : idx_q + 8'd1;
        ctb_d    = ctb_q + {4'b0000, byte_hits};
        cto_d    = cto_q + {7'b0, |win_m[3:0]};
        cts_d    = cts_q + {4'b0000, (idx_q == 8'd0) ? byte_hits : win_hits};
        prev_d   = mem_rd_data[3:0];
        if (last_byte) state_d = WR_B;
        else           idx_d   = idx_q + 8'd1;
      end
      WR_B: begin
        mem_addr    = 8'(RES_ADDR);
        mem_wr_en   = 1'b1;
        mem_wr_data = ctb_q;
        state_d     = WR_O;
      end
      WR_O: begin
        mem_addr    = 8'(RES_ADDR + 1);
        mem_wr_en   = 1'b1;
        mem_wr_data = cto_q;
        state_d     = WR_S;
      end
      WR_S: begin
        mem_addr    = 8'(RES_ADDR + 2);
        mem_wr_en   = 1'b1;
        mem_wr_data = cts_q;
        state_d     = DONE;
      end
      DONE: begin
        ack = 1'b1;
        if (start) state_d = RD_PAT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      ctb_q   <= '0;
      cto_q   <= '0;
      cts_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      ctb_q   <= ctb_d;
      cto_q   <= cto_d;
      cts_q   <= cts_d;
      prev_q  <= prev_d;
    end
  end

endmodule
